// File: rtl/hamming_uart_pkg.sv
// rtl/hamming_uart_pkg.sv - shared types and constants for the serial Hamming(7,4) receive path
package hamming_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_DONE      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  localparam int CODE_BITS = 7;
  localparam int DATA_BITS = 4;

  // Zero-based bit positions of c1..c7 inside the received codeword
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D1_POS = 2;
  localparam int P3_POS = 3;
  localparam int D2_POS = 4;
  localparam int D3_POS = 5;
  localparam int D4_POS = 6;

endpackage

// File: rtl/hamming74_correct.sv
// rtl/hamming74_correct.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming74_correct
  import hamming_uart_pkg::*;
(
  input  logic [CODE_BITS-1:0] code_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic [2:0]           syndrome_o,
  output logic                 corrected_o
);

  logic [CODE_BITS-1:0] fixed;
  logic [2:0]           syn;

  always_comb begin
    syn[2] = code_i[P3_POS] ^ code_i[D2_POS] ^ code_i[D3_POS] ^ code_i[D4_POS];
    syn[1] = code_i[P2_POS] ^ code_i[D1_POS] ^ code_i[D3_POS] ^ code_i[D4_POS];
    syn[0] = code_i[P1_POS] ^ code_i[D1_POS] ^ code_i[D2_POS] ^ code_i[D4_POS];
    fixed  = code_i;
    // A nonzero syndrome is the 1-based position of the bit to flip
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~code_i[syn - 3'd1];
    end
    syndrome_o  = syn;
    corrected_o = (syn != 3'd0);
    data_o      = {fixed[D4_POS], fixed[D3_POS], fixed[D2_POS], fixed[D1_POS]};
  end

endmodule

// File: rtl/hamming_uart_rx_ctrl.sv
// rtl/hamming_uart_rx_ctrl.sv - framed serial receiver feeding the Hamming(7,4) corrector
module hamming_uart_rx_ctrl
  import hamming_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_in,
  output logic [3:0] data_out,
  output logic       valid_out,
  output logic       corrected_out,
  output logic       frame_err_out,
  output logic       busy_out
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [CODE_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 corr_q, corr_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;

  logic [DATA_BITS-1:0] dec_data;
  logic [2:0]           unused_dec_syndrome;
  logic                 dec_corr;

  hamming74_correct u_correct (
    .code_i      (shift_q),
    .data_o      (dec_data),
    .syndrome_o  (unused_dec_syndrome),
    .corrected_o (dec_corr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    corr_d  = corr_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_d[idx_q] = rx_s_q;
            cnt_d          = '0;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'(CODE_BITS - 1)) begin
              idx_d   = 3'd0;
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT_HIGH;
              ferr_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          data_d  = dec_data;
          corr_d  = dec_corr;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        ST_WAIT_HIGH: begin
          // Holding here keeps a stuck-low line from looking like a new start bit
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      corr_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      corr_q    <= corr_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out      = data_q;
  assign corrected_out = corr_q;
  assign valid_out     = valid_q;
  assign frame_err_out = ferr_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hamming_uart_rx_ctrl.sv
// tb/tb_hamming_uart_rx_ctrl.sv - randomized self-checking bench for hamming_uart_rx_ctrl
module tb_hamming_uart_rx_ctrl;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rx_in;
  logic [3:0] data_out;
  logic       valid_out;
  logic       corrected_out;
  logic       frame_err_out;
  logic       busy_out;

  logic [6:0] ref_cw;
  logic [3:0] ref_data;
  logic [2:0] ref_syn;
  logic       ref_corr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int v_cnt   = 0;
  int fe_cnt  = 0;
  int v_cyc   = 0;

  hamming_uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .rx_in         (rx_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .corrected_out (corrected_out),
    .frame_err_out (frame_err_out),
    .busy_out      (busy_out)
  );

  hamming74_correct u_ref_dec (
    .code_i      (ref_cw),
    .data_o      (ref_data),
    .syndrome_o  (ref_syn),
    .corrected_o (ref_corr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      v_cnt = v_cnt + 1;
      v_cyc = cyc;
    end
    if (frame_err_out === 1'b1) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hamming(7,4) encoder straight from the parity equations: c1..c7 = p1 p2 d1 p3 d2 d3 d4
  function automatic logic [6:0] encode(input logic [3:0] n);
    logic d1, d2, d3, d4;
    d1 = n[0]; d2 = n[1]; d3 = n[2]; d4 = n[3];
    return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
  endfunction

  task automatic send_frame(input logic [6:0] cw, input logic stop, input int gap, output int start_cyc);
    rx_in     = 1'b0;
    start_cyc = cyc;
    repeat (CPB) tick();
    for (int i = 0; i < 7; i++) begin
      rx_in = cw[i];
      for (int j = 0; j < CPB; j++) begin
        if (gap > 0 && i == 3 && j == 2) begin
          ena = 1'b0;
          repeat (gap) tick();
          ena = 1'b1;
        end
        tick();
      end
    end
    rx_in = stop;
    repeat (CPB) tick();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy_out !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check({tag, "_idle_timeout"}, (k < 100), 1);
    repeat (4) tick();
  endtask

  task automatic run_frame(input string tag, input logic [6:0] cw, input int gap,
                           input logic [3:0] exp_d, input logic exp_c, input logic [2:0] exp_s,
                           output int lat);
    int v0, f0, st;
    v0 = v_cnt;
    f0 = fe_cnt;
    ref_cw = cw;
    #1;
    check({tag, "_syndrome"}, ref_syn, exp_s);
    send_frame(cw, 1'b1, gap, st);
    rx_in = 1'b1;
    wait_idle(tag);
    check({tag, "_valid_count"}, v_cnt - v0, 1);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_corrected"}, corrected_out, exp_c);
    check({tag, "_frame_err_count"}, fe_cnt - f0, 0);
    lat = v_cyc - st;
  endtask

  initial begin
    int lat0, lat, st, v0, f0;
    logic [3:0] nib, prev_data;
    logic [6:0] cw;
    int flip, gap;

    rst   = 1'b1;
    ena   = 1'b1;
    rx_in = 1'b1;
    ref_cw = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_data", data_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_corrected", corrected_out, 0);
    check("reset_frame_err", frame_err_out, 0);
    check("reset_busy", busy_out, 0);
    repeat (4) tick();

    run_frame("clean_1011", 7'b1010101, 0, 4'b1011, 1'b0, 3'd0, lat0);
    run_frame("c5_flip", 7'b1000101, 0, 4'b1011, 1'b1, 3'd5, lat);
    check("c5_flip_latency", lat, lat0);
    run_frame("ena_gap10", 7'b1010101, 10, 4'b1011, 1'b0, 3'd0, lat);
    check("ena_gap10_latency", lat, lat0 + 10);

    v0 = v_cnt;
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (10) tick();
    check("glitch_busy", busy_out, 0);
    check("glitch_valid_count", v_cnt - v0, 0);

    v0 = v_cnt;
    f0 = fe_cnt;
    prev_data = data_out;
    send_frame(encode(4'b0101), 1'b0, 0, st);
    repeat (20) tick();
    check("stop_err_busy_held", busy_out, 1);
    check("stop_err_pulse_count", fe_cnt - f0, 1);
    check("stop_err_valid_count", v_cnt - v0, 0);
    check("stop_err_data_kept", data_out, prev_data);
    rx_in = 1'b1;
    wait_idle("stop_err_release");
    check("stop_err_busy_release", busy_out, 0);

    v0 = v_cnt;
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx_in = encode(4'b1111) >> i;
      repeat (CPB) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy_out, 0);
    check("rst_data", data_out, 0);
    rx_in = 1'b1;
    repeat (3 * CPB) tick();
    check("rst_no_strobe", v_cnt - v0, 0);
    run_frame("after_rst_0110", encode(4'b0110), 0, 4'b0110, 1'b0, 3'd0, lat);

    for (int i = 0; i < 12; i++) begin
      nib  = 4'($urandom_range(0, 15));
      flip = $urandom_range(0, 7);
      gap  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      cw   = encode(nib);
      if (flip < 7) cw[flip] = ~cw[flip];
      run_frame($sformatf("rnd%0d", i), cw, gap, nib, (flip < 7),
                (flip < 7) ? 3'(flip + 1) : 3'd0, lat);
      check($sformatf("rnd%0d_latency", i), lat, lat0 + gap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
